// File: rtl/fpu_pipe_pkg.sv
// Shared FPU pipeline bundle definitions: widths, field offsets, pack/unpack helpers.
// Stage registers stay field-agnostic; only producers/consumers use the structs.
package fpu_pipe_pkg;

   localparam int RM_W           = 3;
   localparam int EXP10_W        = 10;
   localparam int INF_NAN_FRAC_W = 22;
   localparam int MUL_Z_W        = 48;
   localparam int ADD_SIG_W      = 27;

   localparam int MUL_A2N_W   = RM_W + 1 + EXP10_W + 1 + INF_NAN_FRAC_W + MUL_Z_W;
   localparam int ADD_ALIGN_W = RM_W + 1 + EXP10_W + 1 + INF_NAN_FRAC_W + 2 * ADD_SIG_W;

   // Bit offsets of the mul a2n bundle, LSB first
   localparam int MUL_Z_LSB            = 0;
   localparam int MUL_INF_NAN_FRAC_LSB = MUL_Z_LSB + MUL_Z_W;
   localparam int MUL_IS_INF_NAN_BIT   = MUL_INF_NAN_FRAC_LSB + INF_NAN_FRAC_W;
   localparam int MUL_EXP10_LSB        = MUL_IS_INF_NAN_BIT + 1;
   localparam int MUL_SIGN_BIT         = MUL_EXP10_LSB + EXP10_W;
   localparam int MUL_RM_LSB           = MUL_SIGN_BIT + 1;

   typedef struct packed {
      logic [RM_W-1:0]           rm;
      logic                      sign;
      logic [EXP10_W-1:0]        exp10;
      logic                      is_inf_nan;
      logic [INF_NAN_FRAC_W-1:0] inf_nan_frac;
      logic [MUL_Z_W-1:0]        z;
   } mul_a2n_t;

   typedef struct packed {
      logic [RM_W-1:0]           rm;
      logic                      sign;
      logic [EXP10_W-1:0]        exp10;
      logic                      is_inf_nan;
      logic [INF_NAN_FRAC_W-1:0] inf_nan_frac;
      logic [ADD_SIG_W-1:0]      sig_a;
      logic [ADD_SIG_W-1:0]      sig_b;
   } add_align_t;

   function automatic logic [MUL_A2N_W-1:0] pack_mul_a2n(input mul_a2n_t b);
      return b;
   endfunction

   function automatic mul_a2n_t unpack_mul_a2n(input logic [MUL_A2N_W-1:0] v);
      return mul_a2n_t'(v);
   endfunction

   function automatic logic [ADD_ALIGN_W-1:0] pack_add_align(input add_align_t b);
      return b;
   endfunction

   function automatic add_align_t unpack_add_align(input logic [ADD_ALIGN_W-1:0] v);
      return add_align_t'(v);
   endfunction

endpackage

// File: rtl/fpu_pipe_data_reg.sv
// W-bit data register with load enable; optional synchronous clear. Latency 1 cycle, no flow control.
module fpu_pipe_data_reg #(
   parameter int W   = 1,
   parameter bit RST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (RST && !rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fpu_pipe_stage_skid.sv
// Valid/ready FPU stage register, optional 2-entry skid (registered in_ready), flush and occupancy.
// Latency 1 cycle, 1 bundle/cycle; output held stable while out_valid & ~out_ready.
module fpu_pipe_stage_skid
   import fpu_pipe_pkg::*;
#(
   parameter int DATA_W   = MUL_A2N_W,
   parameter bit SKID     = 1'b1,
   parameter bit RST_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ
);

   logic              drain;
   logic              acc;
   logic              out_valid_q;
   logic              skid_valid_q;
   logic              main_load;
   logic [DATA_W-1:0] main_d;

   // Output slot is free or leaving this cycle
   assign drain = ~out_valid_q | out_ready;
   assign acc   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         out_valid_q <= 1'b0;
      end else if (drain) begin
         out_valid_q <= skid_valid_q | acc;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_data;

         always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
               skid_valid_q <= 1'b0;
            end else if (drain) begin
               skid_valid_q <= 1'b0;
            end else if (acc) begin
               skid_valid_q <= 1'b1;
            end
         end

         fpu_pipe_data_reg #(.W(DATA_W), .RST(RST_DATA)) u_skid_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (acc & ~drain),
            .d     (in_data),
            .q     (skid_data)
         );

         // A held skid entry always refills the output before any newer input
         assign main_d    = skid_valid_q ? skid_data : in_data;
         assign main_load = drain & (skid_valid_q | acc);
         assign in_ready  = ~skid_valid_q;
      end else begin : g_single
         assign skid_valid_q = 1'b0;
         assign main_d       = in_data;
         assign main_load    = drain & acc;
         assign in_ready     = drain;
      end
   endgenerate

   fpu_pipe_data_reg #(.W(DATA_W), .RST(RST_DATA)) u_main_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .d     (main_d),
      .q     (out_data)
   );

   assign out_valid = out_valid_q;
   assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_fpu_pipe_stage_skid.sv
// Bench for fpu_pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus; a queue model
// per instance is checked every cycle, plus directed literal expectations.
module tb_fpu_pipe_stage_skid;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;

   logic         rdy1, ov1, rdy0, ov0;
   logic [W-1:0] od1, od0;
   logic [1:0]   occ1, occ0;

   int  passed = 0;
   int  total  = 0;
   bit  started = 1'b0;

   logic [W-1:0] m1[$];
   logic [W-1:0] m0[$];

   always #5 clk = ~clk;

   fpu_pipe_stage_skid #(.DATA_W(W), .SKID(1'b1), .RST_DATA(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occ(occ1)
   );

   fpu_pipe_stage_skid #(.DATA_W(W), .SKID(1'b0), .RST_DATA(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occ(occ0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Model: a stage is an in-order queue of capacity 2 (skid) or 1 (single reg)
   always @(posedge clk) begin : model
      bit a1, a0, p1, p0;
      if (!rst_n) begin
         m1.delete();
         m0.delete();
      end else begin
         a1 = in_valid && (m1.size() < 2);
         p1 = (m1.size() > 0) && out_ready;
         a0 = in_valid && ((m0.size() == 0) || out_ready);
         p0 = (m0.size() > 0) && out_ready;
         if (flush) begin
            m1.delete();
            m0.delete();
         end else begin
            if (p1) void'(m1.pop_front());
            if (a1) m1.push_back(in_data);
            if (p0) void'(m0.pop_front());
            if (a0) m0.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("s1_out_valid", 32'(ov1), 32'(m1.size() > 0));
         chk("s1_occ", 32'(occ1), 32'(m1.size()));
         chk("s1_in_ready", 32'(rdy1), 32'(m1.size() < 2));
         if (m1.size() > 0) chk("s1_out_data", 32'(od1), 32'(m1[0]));
         chk("s0_out_valid", 32'(ov0), 32'(m0.size() > 0));
         chk("s0_occ", 32'(occ0), 32'(m0.size()));
         chk("s0_in_ready", 32'(rdy0), 32'((m0.size() == 0) || out_ready));
         if (m0.size() > 0) chk("s0_out_data", 32'(od0), 32'(m0[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 16'h0055, 1'b0, 1'b0);
      tick();
      started = 1'b1;
      tick();
      chk("rst_s1_valid", 32'(ov1), 32'd0);
      chk("rst_s1_occ", 32'(occ1), 32'd0);
      chk("rst_s0_valid", 32'(ov0), 32'd0);
      chk("rst_s0_data_zero", 32'(od0), 32'd0);
      rst_n = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
      chk("rel_s1_in_ready", 32'(rdy1), 32'd1);
      chk("rel_s0_in_ready", 32'(rdy0), 32'd1);
      chk("rel_s1_occ", 32'(occ1), 32'd0);

      // Streaming, no bubbles
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, W'(i), 1'b1, 1'b0);
         tick();
         chk("strm_s1_data", 32'(od1), 32'(i));
         chk("strm_s0_data", 32'(od0), 32'(i));
         chk("strm_s1_valid", 32'(ov1), 32'd1);
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      chk("strm_end_s1_valid", 32'(ov1), 32'd0);
      chk("strm_end_s0_valid", 32'(ov0), 32'd0);

      // Stall: A held, B in skid, C waits
      drive(1'b1, 16'h000A, 1'b0, 1'b0);
      tick();
      chk("stall_a_s1_data", 32'(od1), 32'h000A);
      chk("stall_a_s1_occ", 32'(occ1), 32'd1);
      drive(1'b1, 16'h000B, 1'b0, 1'b0);
      tick();
      chk("stall_b_s1_occ", 32'(occ1), 32'd2);
      chk("stall_b_s1_data", 32'(od1), 32'h000A);
      chk("stall_b_s1_in_ready", 32'(rdy1), 32'd0);
      chk("stall_s0_in_ready", 32'(rdy0), 32'd0);
      chk("stall_s0_data_held", 32'(od0), 32'h000A);
      drive(1'b1, 16'h000C, 1'b0, 1'b0);
      tick();
      chk("stall_c_s1_occ", 32'(occ1), 32'd2);
      chk("stall_c_s1_data", 32'(od1), 32'h000A);
      chk("stall_c_s0_data", 32'(od0), 32'h000A);
      drive(1'b1, 16'h000C, 1'b1, 1'b0);
      tick();
      chk("rel_b_s1_data", 32'(od1), 32'h000B);
      chk("rel_b_s1_occ", 32'(occ1), 32'd1);
      chk("rel_c_s0_data", 32'(od0), 32'h000C);
      tick();
      chk("rel_c_s1_data", 32'(od1), 32'h000C);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      chk("rel_end_s1_valid", 32'(ov1), 32'd0);
      chk("rel_end_s0_valid", 32'(ov0), 32'd0);

      // Flush with full skid; s0 accepts D in the flush cycle
      drive(1'b1, 16'h000E, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h000F, 1'b0, 1'b0);
      tick();
      chk("fl_pre_s1_occ", 32'(occ1), 32'd2);
      drive(1'b1, 16'h000D, 1'b1, 1'b1);
      tick();
      chk("fl_s1_valid", 32'(ov1), 32'd0);
      chk("fl_s1_occ", 32'(occ1), 32'd0);
      chk("fl_s0_occ", 32'(occ0), 32'd0);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      chk("fl_post_s1_valid", 32'(ov1), 32'd0);
      chk("fl_post_s0_valid", 32'(ov0), 32'd0);

      // Flush while s1 accepts D
      drive(1'b1, 16'h0009, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h000D, 1'b0, 1'b1);
      tick();
      chk("fl2_s1_occ", 32'(occ1), 32'd0);
      chk("fl2_s0_occ", 32'(occ0), 32'd0);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      chk("fl2_post_s1_valid", 32'(ov1), 32'd0);

      // Random traffic; idle data is X and must never surface
      for (int n = 0; n < 10000; n++) begin
         logic v;
         v = ($urandom_range(0, 99) < 60);
         drive(v, v ? W'($urandom) : 'x, ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 5));
         tick();
      end
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      repeat (4) tick();
      chk("drain_s1_occ", 32'(occ1), 32'd0);
      chk("drain_s0_occ", 32'(occ0), 32'd0);

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
